// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use stall and flush bubbles
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_aluop,
  input  logic          id_regdst,
  input  logic          id_alusrc,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          id_branch,
  input  logic          flush,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [5:0]    ex_funct,
  output logic [1:0]    ex_aluop,
  output logic          ex_regdst,
  output logic          ex_alusrc,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          hazard_stall,
  output logic [CW-1:0] bubble_cnt
);

  logic          valid_d,    valid_q;
  logic [RW-1:0] rs_d,       rs_q;
  logic [RW-1:0] rt_d,       rt_q;
  logic [RW-1:0] rd_d,       rd_q;
  logic [DW-1:0] rdata1_d,   rdata1_q;
  logic [DW-1:0] rdata2_d,   rdata2_q;
  logic [DW-1:0] imm_d,      imm_q;
  logic [5:0]    funct_d,    funct_q;
  logic [1:0]    aluop_d,    aluop_q;
  logic          regdst_d,   regdst_q;
  logic          alusrc_d,   alusrc_q;
  logic          memread_d,  memread_q;
  logic          memwrite_d, memwrite_q;
  logic          regwrite_d, regwrite_q;
  logic          memtoreg_d, memtoreg_q;
  logic          branch_d,   branch_q;
  logic [CW-1:0] bubble_cnt_d, bubble_cnt_q;

  logic          load_use;
  logic          load_bubble;
  logic          cnt_full;

  // A load in EX writing a nonzero register that the ID instruction reads
  always_comb begin
    load_use = id_valid & valid_q & memread_q & (rt_q != '0) &
               ((rt_q == id_rs) | (rt_q == id_rt));
  end

  always_comb begin
    load_bubble = flush | load_use;
    cnt_full    = &bubble_cnt_q;
  end

  always_comb begin
    valid_d      = 1'b0;
    rs_d         = '0;
    rt_d         = '0;
    rd_d         = '0;
    rdata1_d     = '0;
    rdata2_d     = '0;
    imm_d        = '0;
    funct_d      = '0;
    aluop_d      = '0;
    regdst_d     = 1'b0;
    alusrc_d     = 1'b0;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    regwrite_d   = 1'b0;
    memtoreg_d   = 1'b0;
    branch_d     = 1'b0;
    bubble_cnt_d = bubble_cnt_q;

    if (load_bubble) begin
      if (!cnt_full) begin
        bubble_cnt_d = bubble_cnt_q + CW'(1);
      end
    end else begin
      valid_d  = id_valid;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      funct_d  = id_funct;
      aluop_d  = id_aluop;
      // Controls only follow a real instruction so an empty slot never acts
      if (id_valid) begin
        regdst_d   = id_regdst;
        alusrc_d   = id_alusrc;
        memread_d  = id_memread;
        memwrite_d = id_memwrite;
        regwrite_d = id_regwrite;
        memtoreg_d = id_memtoreg;
        branch_d   = id_branch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      aluop_q      <= '0;
      regdst_q     <= 1'b0;
      alusrc_q     <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      branch_q     <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      aluop_q      <= aluop_d;
      regdst_q     <= regdst_d;
      alusrc_q     <= alusrc_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      branch_q     <= branch_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    ex_valid     = valid_q;
    ex_rs        = rs_q;
    ex_rt        = rt_q;
    ex_rd        = rd_q;
    ex_rdata1    = rdata1_q;
    ex_rdata2    = rdata2_q;
    ex_imm       = imm_q;
    ex_funct     = funct_q;
    ex_aluop     = aluop_q;
    ex_regdst    = regdst_q;
    ex_alusrc    = alusrc_q;
    ex_memread   = memread_q;
    ex_memwrite  = memwrite_q;
    ex_regwrite  = regwrite_q;
    ex_memtoreg  = memtoreg_q;
    ex_branch    = branch_q;
    hazard_stall = load_use;
    bubble_cnt   = bubble_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes predicted results, monitors pop and compare.
`default_nettype none

module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rdata1, rdata2, imm;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        regdst, alusrc, memread, memwrite, regwrite, memtoreg, branch;
  } id_t;

  typedef struct packed {
    id_t         f;
    logic [15:0] cnt;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  id_t  idv = '0;

  logic        ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite;
  logic        ex_regwrite, ex_memtoreg, ex_branch, hazard_stall;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [5:0]  ex_funct;
  logic [1:0]  ex_aluop;
  logic [15:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(idv.valid),
    .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd),
    .id_rdata1(idv.rdata1), .id_rdata2(idv.rdata2), .id_imm(idv.imm),
    .id_funct(idv.funct), .id_aluop(idv.aluop),
    .id_regdst(idv.regdst), .id_alusrc(idv.alusrc), .id_memread(idv.memread),
    .id_memwrite(idv.memwrite), .id_regwrite(idv.regwrite),
    .id_memtoreg(idv.memtoreg), .id_branch(idv.branch), .flush(flush),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_funct(ex_funct), .ex_aluop(ex_aluop),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  int total = 0;
  int bad = 0;
  ex_t  model = '0;
  ex_t  sq[$];
  logic hq[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ex_t dut_state();
    ex_t s;
    s.f = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_funct,
           ex_aluop, ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite,
           ex_memtoreg, ex_branch};
    s.cnt = bubble_cnt;
    return s;
  endfunction

  // Reference: a load in EX blocks a dependent ID instruction
  function automatic bit ref_hazard(input ex_t s, input id_t i);
    return s.f.valid && s.f.memread && s.f.rt != 0 && i.valid &&
           (s.f.rt == i.rs || s.f.rt == i.rt);
  endfunction

  function automatic ex_t ref_next(input ex_t s, input id_t i, input bit fl);
    ex_t n;
    int  c;
    n = '0;
    n.cnt = s.cnt;
    if (fl || ref_hazard(s, i)) begin
      c = int'(s.cnt) + 1;
      n.cnt = (c > 65535) ? 16'hFFFF : 16'(c);
    end else if (i.valid) begin
      n.f = i;
    end else begin
      n.f.rs = i.rs;  n.f.rt = i.rt;  n.f.rd = i.rd;
      n.f.rdata1 = i.rdata1;  n.f.rdata2 = i.rdata2;  n.f.imm = i.imm;
      n.f.funct = i.funct;  n.f.aluop = i.aluop;
    end
    return n;
  endfunction

  function automatic id_t rand_id();
    id_t i;
    i.valid    = ($urandom_range(0, 9) != 0);
    i.rs       = 5'($urandom_range(0, 7));
    i.rt       = 5'($urandom_range(0, 7));
    i.rd       = 5'($urandom);
    i.rdata1   = $urandom;
    i.rdata2   = $urandom;
    i.imm      = $urandom;
    i.funct    = 6'($urandom);
    i.aluop    = 2'($urandom_range(0, 2));
    i.regdst   = 1'($urandom);
    i.alusrc   = 1'($urandom);
    i.memread  = ($urandom_range(0, 2) == 0);
    i.memwrite = 1'($urandom);
    i.regwrite = 1'($urandom);
    i.memtoreg = 1'($urandom);
    i.branch   = 1'($urandom);
    return i;
  endfunction

  function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [1:0] aluop, input logic [5:0] funct,
                             input bit mr, input bit mw, input bit rw);
    id_t i;
    i = '0;
    i.valid = 1'b1;
    i.rs = rs;  i.rt = rt;  i.rd = rd;
    i.rdata1 = $urandom;  i.rdata2 = $urandom;  i.imm = $urandom;
    i.aluop = aluop;  i.funct = funct;
    i.memread = mr;  i.memwrite = mw;  i.regwrite = rw;
    i.alusrc = mr | mw;  i.memtoreg = mr;  i.regdst = (aluop == 2'b10);
    return i;
  endfunction

  // One cycle of stimulus: drive, predict, push
  task automatic step(input id_t i, input bit fl);
    @(negedge clk);
    idv = i;
    flush = fl;
    #1;
    hq.push_back(ref_hazard(model, i));
    model = ref_next(model, i, fl);
    sq.push_back(model);
  endtask

  initial begin : mon_state
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("ex_state", 256'(dut_state().f), 256'(e.f));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(e.cnt));
      end
    end
  end

  initial begin : mon_hazard
    logic h;
    forever begin
      @(negedge clk);
      #2;
      if (hq.size() != 0) begin
        h = hq.pop_front();
        chk("hazard_stall", 256'(hazard_stall), 256'(h));
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    id_t cur, add;
    bit  haz, fl;

    #12;
    chk("reset_state", 256'(dut_state()), 256'(0));
    chk("reset_hazard", 256'(hazard_stall), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add
    step(mk(5'd1, 5'd2, 5'd3, 2'b10, 6'b100000, 0, 0, 1), 0);
    step('0, 0);
    chk("add_funct", 256'(ex_funct), 256'(6'b100000));
    chk("add_rd_regwrite", 256'({ex_valid, ex_aluop, ex_rd, ex_regwrite}), 256'({1'b1, 2'b10, 5'd3, 1'b1}));

    // Load-use: lw rt=5, then add rs=5 presented twice
    step(mk(5'd1, 5'd5, 5'd0, 2'b00, 6'd0, 1, 0, 1), 0);
    add = mk(5'd5, 5'd4, 5'd6, 2'b10, 6'b100000, 0, 0, 1);
    step(add, 0);
    step(add, 0);
    chk("lu_cnt", 256'(bubble_cnt), 256'(16'd1));
    step('0, 0);
    chk("lu_add_in_ex", 256'({ex_valid, ex_rs, ex_rd}), 256'({1'b1, 5'd5, 5'd6}));

    // Load to $zero never stalls
    step(mk(5'd1, 5'd0, 5'd0, 2'b00, 6'd0, 1, 0, 1), 0);
    step(mk(5'd0, 5'd0, 5'd7, 2'b10, 6'b100010, 0, 0, 1), 0);
    // Load matching both sources, then flush on top of a hazard
    step(mk(5'd2, 5'd6, 5'd0, 2'b00, 6'd0, 1, 0, 1), 0);
    add = mk(5'd6, 5'd6, 5'd9, 2'b10, 6'b100000, 0, 0, 1);
    step(add, 0);
    step(add, 0);
    step(mk(5'd2, 5'd6, 5'd0, 2'b00, 6'd0, 1, 0, 1), 0);
    step(add, 1);
    step(add, 0);

    // Randomized traffic; a stalled instruction is re-presented
    cur = rand_id();
    for (int n = 0; n < 600; n++) begin
      haz = ref_hazard(model, cur);
      fl = ($urandom_range(0, 9) == 0);
      step(cur, fl);
      if (!haz || fl) cur = rand_id();
    end

    // Async reset while a valid sw sits in EX
    step(mk(5'd3, 5'd4, 5'd0, 2'b00, 6'd0, 0, 1, 0), 0);
    step('0, 0);
    step(mk(5'd3, 5'd4, 5'd0, 2'b00, 6'd0, 0, 1, 0), 1);
    step(mk(5'd3, 5'd4, 5'd0, 2'b00, 6'd0, 0, 1, 0), 0);
    @(negedge clk);
    idv = '0;
    flush = 1'b0;
    #3;
    chk("sw_in_ex", 256'({ex_valid, ex_memwrite}), 256'({1'b1, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 256'(dut_state()), 256'(0));
    chk("async_rst_hazard", 256'(hazard_stall), 256'(0));
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Drive the counter to saturation
    for (int n = 0; n < 65534; n++) step(rand_id(), 1);
    chk("cnt_fffe", 256'(model.cnt), 256'(16'hFFFE));
    for (int n = 0; n < 3; n++) step(rand_id(), 1);
    step('0, 0);
    chk("cnt_sat", 256'(bubble_cnt), 256'(16'hFFFF));
    for (int n = 0; n < 20; n++) step(rand_id(), 0);

    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", 256'(sq.size() + hq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
